// File: rtl/mul8_eval_pkg.sv
// Shared types and helpers for the multiplier error monitor.
// Holds the product/operand widths, the run-control states and a 16-bit popcount.
package mul8_eval_pkg;

  localparam int PW  = 16;
  localparam int OPW = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic logic [4:0] popcount16(input logic [PW-1:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < PW; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/mul8_err_stage.sv
// Error stage: exact product, |error|, Hamming distance and mismatch flag, registered.
// flush_i drops the stage's valid so an aborted run cannot leak into the next one.
module mul8_err_stage
  import mul8_eval_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush_i,
  input  logic           valid_i,
  input  logic [OPW-1:0] a_i,
  input  logic [OPW-1:0] b_i,
  input  logic [PW-1:0]  p_i,
  output logic           valid_o,
  output logic [PW-1:0]  abs_err_o,
  output logic [4:0]     hd_o,
  output logic           ne_o
);

  logic [PW-1:0] exact_d;
  logic [PW:0]   diff_d;
  logic [PW-1:0] abs_err_d;
  logic [4:0]    hd_d;
  logic          ne_d;

  logic          valid_q;
  logic [PW-1:0] abs_err_q;
  logic [4:0]    hd_q;
  logic          ne_q;

  always_comb begin
    exact_d   = PW'(a_i) * PW'(b_i);
    // The sign bit of the widened difference picks which way round to subtract.
    diff_d    = {1'b0, exact_d} - {1'b0, p_i};
    abs_err_d = diff_d[PW] ? (p_i - exact_d) : diff_d[PW-1:0];
    hd_d      = popcount16(exact_d ^ p_i);
    ne_d      = (exact_d != p_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      abs_err_q <= '0;
      hd_q      <= '0;
      ne_q      <= 1'b0;
    end else begin
      valid_q   <= flush_i ? 1'b0 : valid_i;
      abs_err_q <= abs_err_d;
      hd_q      <= hd_d;
      ne_q      <= ne_d;
    end
  end

  assign valid_o   = valid_q;
  assign abs_err_o = abs_err_q;
  assign hd_o      = hd_q;
  assign ne_o      = ne_q;

endmodule

// File: rtl/mul8_err_monitor.sv
// Scores an 8x8 multiplier under test: streams (a, b, p_dut) and accumulates
// sum/max of |error|, erroneous-sample count and summed Hamming distance.
module mul8_err_monitor
  import mul8_eval_pkg::*;
#(
  parameter int NW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NW-1:0]    num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  input  logic [PW-1:0]    p_dut,
  output logic             busy,
  output logic             done,
  output logic [PW+NW-1:0] sum_abs_err,
  output logic [PW-1:0]    max_abs_err,
  output logic [NW-1:0]    err_count,
  output logic [NW+4:0]    hd_sum
);

  state_e            state_q, state_d;
  logic [NW-1:0]     num_q;
  logic [NW-1:0]     acc_cnt_q;
  logic              s1_valid_q;
  logic [OPW-1:0]    s1_a_q, s1_b_q;
  logic [PW-1:0]     s1_p_q;
  logic [PW+NW-1:0]  sum_q;
  logic [PW-1:0]     max_q;
  logic [NW-1:0]     cnt_q;
  logic [NW+4:0]     hd_sum_q;

  logic              s2_valid;
  logic [PW-1:0]     s2_abs_err;
  logic [4:0]        s2_hd;
  logic              s2_ne;
  logic              accept;

  mul8_err_stage u_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (start),
    .valid_i   (s1_valid_q),
    .a_i       (s1_a_q),
    .b_i       (s1_b_q),
    .p_i       (s1_p_q),
    .valid_o   (s2_valid),
    .abs_err_o (s2_abs_err),
    .hd_o      (s2_hd),
    .ne_o      (s2_ne)
  );

  // start wins over a same-cycle handshake, so ready is masked while it is high.
  assign in_ready = (state_q == ST_RUN) && (acc_cnt_q < num_q) && !start;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = (num_samples == '0) ? ST_DONE : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   if (accept && (acc_cnt_q + NW'(1) == num_q)) state_d = ST_DRAIN;
        ST_DRAIN: if (!s1_valid_q && !s2_valid) state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      num_q      <= '0;
      acc_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_p_q     <= '0;
      sum_q      <= '0;
      max_q      <= '0;
      cnt_q      <= '0;
      hd_sum_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        num_q      <= num_samples;
        acc_cnt_q  <= '0;
        s1_valid_q <= 1'b0;
        sum_q      <= '0;
        max_q      <= '0;
        cnt_q      <= '0;
        hd_sum_q   <= '0;
      end else begin
        s1_valid_q <= accept;
        if (accept) begin
          acc_cnt_q <= acc_cnt_q + NW'(1);
          s1_a_q    <= a;
          s1_b_q    <= b;
          s1_p_q    <= p_dut;
        end
        if (s2_valid) begin
          sum_q    <= sum_q + (PW+NW)'(s2_abs_err);
          cnt_q    <= cnt_q + NW'(s2_ne);
          hd_sum_q <= hd_sum_q + (NW+5)'(s2_hd);
          if (s2_abs_err > max_q) max_q <= s2_abs_err;
        end
      end
    end
  end

  assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign sum_abs_err = sum_q;
  assign max_abs_err = max_q;
  assign err_count   = cnt_q;
  assign hd_sum      = hd_sum_q;

endmodule

// File: tb/tb_mul8_err_monitor.sv
// Directed bench for mul8_err_monitor: hand-computed expectations, immediate assertions.
module tb_mul8_err_monitor;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [NW-1:0] num_samples;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    a, b;
  logic [15:0]   p_dut;
  logic          busy, done;
  logic [31:0]   sum_abs_err;
  logic [15:0]   max_abs_err;
  logic [15:0]   err_count;
  logic [20:0]   hd_sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  va [256];
  logic [7:0]  vb [256];
  logic [15:0] vp [256];

  mul8_err_monitor #(.NW(NW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .p_dut       (p_dut),
    .busy        (busy),
    .done        (done),
    .sum_abs_err (sum_abs_err),
    .max_abs_err (max_abs_err),
    .err_count   (err_count),
    .hd_sum      (hd_sum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string name, input longint e_sum, input longint e_max,
                           input longint e_cnt, input longint e_hd);
    chk({name, "_sum"}, 64'(sum_abs_err), e_sum);
    chk({name, "_max"}, 64'(max_abs_err), e_max);
    chk({name, "_cnt"}, 64'(err_count), e_cnt);
    chk({name, "_hd"},  64'(hd_sum), e_hd);
  endtask

  // Pulses start for one cycle; returns at the negedge where start has just dropped.
  task automatic start_run(input int n);
    @(negedge clk);
    start = 1'b1; num_samples = NW'(n); in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feeds va/vb/vp[0..n-1], then waits for done and checks timing and stats.
  task automatic run_body(input string name, input int n, input bit toggle,
                          input longint e_sum, input longint e_max,
                          input longint e_cnt, input longint e_hd);
    int  idx = 0;
    int  budget = 0;
    int  last = 0;
    bit  phase = 1'b1;
    bit  prev_busy = 1'b1;
    chk_stats({name, "_clr"}, 0, 0, 0, 0);
    while (idx < n && budget < 4000) begin
      in_valid = toggle ? phase : 1'b1;
      phase = ~phase;
      a = va[idx]; b = vb[idx]; p_dut = vp[idx];
      #1;
      if (in_valid && in_ready) begin
        last = cyc;
        idx++;
      end
      budget++;
      @(negedge clk);
    end
    chk({name, "_accepted"}, 64'(idx), 64'(n));
    // Offer an extra sample after the last accept: it must be refused.
    in_valid = 1'b1; a = 8'd255; b = 8'd255; p_dut = 16'd0;
    #1;
    chk({name, "_rdy_after_last"}, 64'(in_ready), 0);
    chk({name, "_busy_drain"}, 64'(busy), 1);
    budget = 0;
    while (!done && budget < 50) begin
      prev_busy = busy;
      @(negedge clk);
      in_valid = ~in_valid;
      budget++;
    end
    in_valid = 1'b0;
    chk({name, "_done_seen"}, 64'(done), 1);
    chk({name, "_done_lat"}, 64'(cyc - last), 4);
    chk({name, "_busy_low"}, 64'(busy), 0);
    chk({name, "_busy_before"}, 64'(prev_busy), 1);
    chk_stats(name, e_sum, e_max, e_cnt, e_hd);
    $display("run %s: n=%0d sum=%0d max=%0d cnt=%0d hd=%0d", name, n,
             sum_abs_err, max_abs_err, err_count, hd_sum);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    a = '0; b = '0; p_dut = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(in_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk_stats("rst", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Exact multiplier, 256 random operands.
    for (int i = 0; i < 256; i++) begin
      va[i] = 8'($urandom_range(0, 255));
      vb[i] = 8'($urandom_range(0, 255));
      vp[i] = 16'(va[i]) * 16'(vb[i]);
    end
    start_run(256);
    run_body("exact", 256, 1'b0, 0, 0, 0, 0);

    // Single large error: 255*255 = 0xFE01 vs 0.
    va[0] = 8'd255; vb[0] = 8'd255; vp[0] = 16'h0000;
    start_run(1);
    run_body("single", 1, 1'b0, 65025, 65025, 1, 8);

    // Errors of both signs: 15 vs 14 and 15 vs 16.
    va[0] = 8'd3; vb[0] = 8'd5; vp[0] = 16'd14;
    va[1] = 8'd3; vb[1] = 8'd5; vp[1] = 16'd16;
    start_run(2);
    run_body("sign", 2, 1'b0, 2, 1, 2, 6);

    // Handshake with in_valid toggling every cycle.
    va[0] = 8'd10; vb[0] = 8'd10; vp[0] = 16'd100;
    va[1] = 8'd10; vb[1] = 8'd10; vp[1] = 16'd101;
    va[2] = 8'd0;  vb[2] = 8'd0;  vp[2] = 16'd0;
    va[3] = 8'd1;  vb[3] = 8'd1;  vp[3] = 16'd0;
    start_run(4);
    run_body("toggle", 4, 1'b1, 2, 1, 2, 2);

    // Zero-length run: DONE directly one cycle after start.
    start_run(0);
    chk("zero_done", 64'(done), 1);
    chk("zero_busy", 64'(busy), 0);
    chk("zero_ready", 64'(in_ready), 0);
    chk_stats("zero", 0, 0, 0, 0);
    $display("run zero: done=%0d busy=%0d", done, busy);

    // Abort with two erroneous samples in flight, then a fresh 2-sample run.
    start_run(4);
    in_valid = 1'b1; a = 8'd255; b = 8'd255; p_dut = 16'd0;
    #1 chk("abort_rdy1", 64'(in_ready), 1);
    @(negedge clk);
    #1 chk("abort_rdy2", 64'(in_ready), 1);
    @(negedge clk);
    start = 1'b1; num_samples = NW'(2);
    #1 chk("abort_rdy_start", 64'(in_ready), 0);
    @(negedge clk);
    start = 1'b0;
    va[0] = 8'd2; vb[0] = 8'd3; vp[0] = 16'd7;
    va[1] = 8'd4; vb[1] = 8'd4; vp[1] = 16'd16;
    run_body("abort", 2, 1'b0, 1, 1, 1, 1);

    // Asynchronous reset while draining.
    start_run(1);
    in_valid = 1'b1; a = 8'd255; b = 8'd255; p_dut = 16'd0;
    #1 chk("arst_accept", 64'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("arst_pre_sum", 64'(sum_abs_err), 65025);
    chk("arst_pre_busy", 64'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(in_ready), 0);
    chk("arst_busy", 64'(busy), 0);
    chk("arst_done", 64'(done), 0);
    chk_stats("arst", 0, 0, 0, 0);
    $display("run arst: busy=%0d sum=%0d", busy, sum_abs_err);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
